// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : count_seq_pkg
// Desc     : Shared state/command encodings and default width for count_sequencer.
// Revision : 1.0
// ============================================================================
package count_seq_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2,
        ST_ONESHOT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_STOP    = 2'd0,
        OP_RUN     = 2'd1,
        OP_LOAD    = 2'd2,
        OP_ONESHOT = 2'd3
    } op_e;

endpackage
`default_nettype wire

// File: rtl/count_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : count_prescaler
// Desc     : Emits one tick every div+1 cycles; clear restarts with a tick next cycle.
// Config   : present only when COUNT_SEQUENCER_PRESCALE_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef COUNT_SEQUENCER_PRESCALE_EN
module count_prescaler #(
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic [PS_W-1:0] div,
    output logic            tick
);

    logic [PS_W-1:0] r_cnt;

    // >= rather than == so a divisor lowered mid-count cannot strand the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt >= div)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == '0);

endmodule
`endif
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : count_sequencer
// Desc     : Command-driven control FSM for an external counter (load/run/oneshot).
// Config   : COUNT_SEQUENCER_PRESCALE_EN adds a run-rate prescaler set via LOAD.
// Revision : 1.0
// ============================================================================
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    if (PS_W > WIDTH) begin : g_ps_w_check
        $error("count_sequencer: PS_W must not exceed WIDTH");
    end

    state_e           r_state;
    state_e           w_next_state;
    logic             r_load;
    logic             w_load_next;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] w_load_val_next;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target_next;
    logic             r_done;
    logic             w_done_next;
    logic             r_busy;
    logic             w_en_raw;
    logic             w_tick;
    op_e              w_op;
    logic             w_accept;
    logic             w_abort;
    logic             w_active;
    logic             w_match;

    assign w_op      = op_e'(cmd_op);
    assign cmd_ready = (r_state != ST_LOADING);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_abort   = w_accept && ((w_op == OP_STOP) || (w_op == OP_LOAD));
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_ONESHOT);
    assign w_match   = (cnt_value == r_target);

`ifdef COUNT_SEQUENCER_PRESCALE_EN
    logic [PS_W-1:0] r_div;
    logic [PS_W-1:0] w_div_next;
    logic            w_ps_clear;

    // Held clear outside RUN/ONESHOT so every entry starts on a tick.
    assign w_ps_clear = !w_active;

    count_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_ps_clear),
        .div   (r_div),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else begin
            r_div <= w_div_next;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_next_state    = r_state;
        w_load_next     = 1'b0;
        w_load_val_next = r_load_val;
        w_target_next   = r_target;
        w_done_next     = 1'b0;
        w_en_raw        = 1'b0;
`ifdef COUNT_SEQUENCER_PRESCALE_EN
        w_div_next      = r_div;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_op == OP_RUN)) begin
                    w_next_state = ST_RUN;
                end else if (w_accept && (w_op == OP_ONESHOT)) begin
                    w_target_next = cmd_data;
                    w_next_state  = ST_ONESHOT;
                end
            end
            ST_LOADING: begin
                w_next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_en_raw = 1'b1;
                end
            end
            ST_ONESHOT: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_match) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_en_raw = 1'b1;
                end
            end
        endcase

        // LOAD from any ready state overrides the per-state decision above.
        if (w_accept && (w_op == OP_LOAD)) begin
`ifdef COUNT_SEQUENCER_PRESCALE_EN
            if (cmd_data[WIDTH-1]) begin
                w_div_next   = cmd_data[PS_W-1:0];
                w_next_state = ST_IDLE;
            end else begin
`endif
                w_load_next     = 1'b1;
                w_load_val_next = cmd_data;
                w_next_state    = ST_LOADING;
`ifdef COUNT_SEQUENCER_PRESCALE_EN
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_load     <= 1'b0;
            r_load_val <= '0;
            r_target   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_load     <= w_load_next;
            r_load_val <= w_load_val_next;
            r_target   <= w_target_next;
            r_done     <= w_done_next;
            r_busy     <= (w_next_state == ST_RUN) || (w_next_state == ST_ONESHOT);
        end
    end

    assign cnt_en       = w_en_raw && w_tick;
    assign cnt_load     = r_load;
    assign cnt_load_val = r_load_val;
    assign busy         = r_busy;
    assign done         = r_done;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_sequencer
// Desc     : Self-checking bench with an external counter and a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_count_sequencer;

    localparam logic [1:0] OP_STOP    = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_LOAD    = 2'd2;
    localparam logic [1:0] OP_ONESHOT = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] cnt_q = 8'h00;
    logic       cnt_en;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    count_sequencer #(
        .WIDTH (8),
        .PS_W  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cnt_value    (cnt_q),
        .cnt_en       (cnt_en),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .busy         (busy),
        .done         (done),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- counter datapath and observation ----------------
    logic       s_en, s_load;
    logic [7:0] s_lval;
    int         en_count   = 0;
    int         done_count = 0;
    int         cyc        = 0;
    int         en_cycles[$];

    always @(posedge clk) begin
        if (s_load) cnt_q <= s_lval;
        else if (s_en) cnt_q <= cnt_q + 8'h01;
    end

    // ---------------- behavioural model ----------------
    // m_st uses the numeric debug codes: 0 idle, 1 loading, 2 run, 3 oneshot.
    int         m_st = 0;
    logic [7:0] m_target = 8'h00;
    logic [7:0] m_lval = 8'h00;
    bit         m_done = 1'b0;
    bit         m_load = 1'b0;
    int         m_div = 0;
    int         m_k = 0;

    function automatic bit m_tick();
`ifdef COUNT_SEQUENCER_PRESCALE_EN
        return (m_k % (m_div + 1)) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit m_en();
        bit acc;
        bit stop_like;
        acc       = cmd_valid && (m_st != 1);
        stop_like = acc && ((cmd_op == OP_STOP) || (cmd_op == OP_LOAD));
        if (m_st == 2) return !stop_like && m_tick();
        if (m_st == 3) return !stop_like && (cnt_q != m_target) && m_tick();
        return 1'b0;
    endfunction

    task automatic m_step();
        bit acc;
        int ns;
        bit nd;
        bit nl;
        bit ps_load;
        acc = cmd_valid && (m_st != 1);
        ns  = m_st;
        nd  = 1'b0;
        nl  = 1'b0;
        ps_load = 1'b0;
`ifdef COUNT_SEQUENCER_PRESCALE_EN
        ps_load = cmd_data[7];
`endif
        if (m_st == 1) begin
            ns = 0;
        end else if (acc && cmd_op == OP_STOP) begin
            ns = 0;
        end else if (acc && cmd_op == OP_LOAD) begin
            if (ps_load) begin
                m_div = int'(cmd_data[3:0]);
                ns    = 0;
            end else begin
                m_lval = cmd_data;
                nl     = 1'b1;
                ns     = 1;
            end
        end else if (m_st == 0 && acc && cmd_op == OP_RUN) begin
            ns = 2;
        end else if (m_st == 0 && acc && cmd_op == OP_ONESHOT) begin
            m_target = cmd_data;
            ns       = 3;
        end else if (m_st == 3 && cnt_q == m_target) begin
            ns = 0;
            nd = 1'b1;
        end
        m_k    = (m_st >= 2 && ns >= 2) ? m_k + 1 : 0;
        m_st   = ns;
        m_done = nd;
        m_load = nl;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_target = 8'h00; m_lval = 8'h00;
            m_done = 1'b0; m_load = 1'b0; m_div = 0; m_k = 0;
        end else begin
            m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("state", 32'(state), 32'(m_st));
        check("busy", 32'(busy), 32'(m_st >= 2));
        check("done", 32'(done), 32'(m_done));
        check("cnt_load", 32'(cnt_load), 32'(m_load));
        check("cnt_load_val", 32'(cnt_load_val), 32'(m_lval));
        check("cmd_ready", 32'(cmd_ready), 32'(m_st != 1));
        check("cnt_en", 32'(cnt_en), 32'(m_en()));
        check("done_and_load", 32'(done && cnt_load), 32'd0);
        s_en   = cnt_en;
        s_load = cnt_load;
        s_lval = cnt_load_val;
        if (rst_n && cnt_en) begin
            en_count++;
            en_cycles.push_back(cyc);
        end
        if (done) done_count++;
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #2;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(ok), 32'd1);
    endtask

    task automatic clear_counts();
        en_count   = 0;
        done_count = 0;
        en_cycles.delete();
    endtask

    task automatic set_count(input logic [7:0] v);
        send(OP_LOAD, 8'h00);
        step(1);
`ifdef COUNT_SEQUENCER_PRESCALE_EN
        if (v[7]) begin
            send(OP_RUN, 8'h00);
            step(int'(v));
            send(OP_STOP, 8'h00);
            step(1);
        end else begin
            send(OP_LOAD, v);
            step(1);
        end
`else
        send(OP_LOAD, v);
        step(1);
`endif
        check("set_count", 32'(cnt_q), 32'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load", 32'(cnt_load), 32'd0);
        rst_n = 1'b1;

        // LOAD 0x10: one LOADING cycle with strobe, then back to idle
        send(OP_LOAD, 8'h10);
        check("ld_strobe", 32'(cnt_load), 32'd1);
        check("ld_val", 32'(cnt_load_val), 32'h10);
        check("ld_ready", 32'(cmd_ready), 32'd0);
        check("ld_state", 32'(state), 32'd1);
        step(1);
        check("ld_back_idle", 32'(state), 32'd0);
        check("ld_strobe_off", 32'(cnt_load), 32'd0);
        check("ld_counter", 32'(cnt_q), 32'h10);

        // ONESHOT 5 from 0
        set_count(8'h00);
        clear_counts();
        send(OP_ONESHOT, 8'h05);
        step(10);
        check("os5_enables", 32'(en_count), 32'd5);
        check("os5_done", 32'(done_count), 32'd1);
        check("os5_busy", 32'(busy), 32'd0);
        check("os5_count", 32'(cnt_q), 32'h05);

        // ONESHOT 2 from 0xFE wraps through 0xFF, 0x00
        set_count(8'hFE);
        clear_counts();
        send(OP_ONESHOT, 8'h02);
        step(10);
        check("wrap_enables", 32'(en_count), 32'd4);
        check("wrap_done", 32'(done_count), 32'd1);
        check("wrap_count", 32'(cnt_q), 32'h02);

        // target already equal on entry
        clear_counts();
        send(OP_ONESHOT, 8'h02);
        step(4);
        check("eq_enables", 32'(en_count), 32'd0);
        check("eq_done", 32'(done_count), 32'd1);
        check("eq_state", 32'(state), 32'd0);

        // RUN, STOP after 7 cycles
        clear_counts();
        send(OP_RUN, 8'h00);
        step(7);
        check("run_busy", 32'(busy), 32'd1);
        check("run_state", 32'(state), 32'd2);
        send(OP_STOP, 8'h00);
        check("stop_enables", 32'(en_count), 32'd7);
        check("stop_done", 32'(done_count), 32'd0);
        check("stop_state", 32'(state), 32'd0);

        // ONESHOT while running is ignored
        clear_counts();
        send(OP_RUN, 8'h00);
        step(2);
        send(OP_ONESHOT, 8'h00);
        step(1);
        check("ign_state", 32'(state), 32'd2);
        send(OP_STOP, 8'h00);
        check("ign_enables", 32'(en_count), 32'd4);

        // LOAD while running goes straight to LOADING
        clear_counts();
        send(OP_RUN, 8'h00);
        step(3);
        send(OP_LOAD, 8'h40);
        check("rl_state", 32'(state), 32'd1);
        check("rl_strobe", 32'(cnt_load), 32'd1);
        check("rl_busy", 32'(busy), 32'd0);
        check("rl_enables", 32'(en_count), 32'd3);
        step(1);
        check("rl_counter", 32'(cnt_q), 32'h40);

        // asynchronous reset mid-ONESHOT
        set_count(8'h11);
        send(OP_ONESHOT, 8'h30);
        step(5);
        clear_counts();
        #1 rst_n = 1'b0;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_en", 32'(cnt_en), 32'd0);
        check("ar_load_val", 32'(cnt_load_val), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("ar_ready_first", 32'(cmd_ready), 32'd1);
        #1;
        send(OP_RUN, 8'h00);
        check("ar_run_state", 32'(state), 32'd2);
        step(2);
        send(OP_STOP, 8'h00);
        step(30);
        check("ar_no_done", 32'(done_count), 32'd0);

`ifdef COUNT_SEQUENCER_PRESCALE_EN
        // LOAD 0x83 sets P=3; RUN for 12 cycles yields enables 4 apart
        set_count(8'h00);
        send(OP_LOAD, 8'h83);
        check("ps_state", 32'(state), 32'd0);
        check("ps_no_strobe", 32'(cnt_load), 32'd0);
        clear_counts();
        send(OP_RUN, 8'h00);
        step(12);
        send(OP_STOP, 8'h00);
        check("ps_enables", 32'(en_count), 32'd3);
        if (en_cycles.size() == 3) begin
            check("ps_gap1", 32'(en_cycles[1] - en_cycles[0]), 32'd4);
            check("ps_gap2", 32'(en_cycles[2] - en_cycles[1]), 32'd4);
        end
        check("ps_counter", 32'(cnt_q), 32'h03);
`endif

        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of counter value, load value and target.
REQ-002 SHALL have parameter PS_W, default 4, width of prescale divisor (used only with COUNT_SEQUENCER_PRESCALE_EN).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_op  in  2  00 STOP, 01 RUN, 10 LOAD, 11 ONESHOT.
- cmd_data  in  WIDTH  load value (LOAD) or target (ONESHOT); ignored otherwise.
- cnt_value  in  WIDTH  current count from the counter datapath.
- cnt_en  out  1  counter increment enable.
- cnt_load  out  1  one-cycle load strobe to the counter.
- cnt_load_val  out  WIDTH  value loaded when cnt_load is high.
- busy  out  1  high in RUN or ONESHOT.
- done  out  1  one-cycle pulse when the ONESHOT target is reached.
- state  out  2  encoded FSM state for debug.

Function
REQ-004 SHALL implement FSM states IDLE=0, LOADING=1, RUN=2, ONESHOT=3.
REQ-005 cmd_ready SHALL be high in IDLE, RUN and ONESHOT, and low in LOADING.
REQ-006 IDLE + LOAD accepted -> LOADING; cnt_load_val<=cmd_data; cnt_load high for exactly the LOADING cycle; return to IDLE next cycle.
REQ-007 IDLE + RUN accepted -> RUN next cycle; cnt_en asserted from the first RUN cycle.
REQ-008 IDLE + ONESHOT accepted -> target<=cmd_data, ONESHOT next cycle; cnt_en asserted while cnt_value != target.
REQ-009 ONESHOT: first cycle with cnt_value == target -> cnt_en low that same cycle (combinational compare), done high for one cycle the next cycle, state -> IDLE.
REQ-010 ONESHOT with target equal to cnt_value on entry SHALL produce no enable pulse and complete per REQ-009.
REQ-011 STOP accepted in any state SHALL move to IDLE next cycle, deassert cnt_en that same cycle, and produce no done pulse.
REQ-012 RUN or ONESHOT accepted while in RUN/ONESHOT SHALL be accepted and ignored; LOAD accepted there SHALL be treated as STOP followed by LOAD (state -> LOADING).
REQ-013 Counter wrap from 2^WIDTH-1 to 0 SHALL not stop RUN; ONESHOT SHALL continue through the wrap until target is matched.
REQ-014 done and cnt_load SHALL never be high in the same cycle.
REQ-015 All outputs SHALL be registered except cnt_en and cmd_ready.

Reset
REQ-016 Asserting rst_n low SHALL immediately force state=IDLE, cnt_en=0, cnt_load=0, cnt_load_val=0, target=0, done=0, busy=0.
REQ-017 Reset mid-operation SHALL abort with no done pulse; the first command is accepted in the first cycle after rst_n deasserts.

Configuration
REQ-018 Macro COUNT_SEQUENCER_PRESCALE_EN defined: LOAD with cmd_data[WIDTH-1] = 1 SHALL instead set prescale divisor P <= cmd_data[PS_W-1:0] without loading the counter.
REQ-019 With the macro, cnt_en SHALL be high one cycle in every P+1 cycles during RUN/ONESHOT.
REQ-020 With the macro, the prescale counter SHALL restart on entry to RUN/ONESHOT, with the first enable on the first cycle; reset value P=0.
REQ-021 Without the macro, no prescale logic exists, cnt_en is continuous, and all LOAD commands load the counter.

Structure
REQ-022 A package count_seq_pkg SHALL hold the state enum, the cmd_op encodings and the default WIDTH.
REQ-023 With the macro, the prescaler SHALL be a sub-module count_prescaler (inputs clk, rst_n, clear, div; output tick).

Verification
REQ-024 Reset, then LOAD 0x10 -> cnt_load high one cycle, cnt_load_val=0x10, cmd_ready low in that cycle, state back to 0.
REQ-025 ONESHOT 0x05 from count 0x00, with a model counter -> exactly 5 cnt_en cycles, done once, busy low after.
REQ-026 ONESHOT 0x02 from count 0xFE -> counts through 0xFF, 0x00, 0x01, 0x02; done once.
REQ-027 RUN, then STOP after 7 cycles -> 7 enables, no done, state=IDLE.
REQ-028 rst_n low mid-ONESHOT -> all outputs at reset values immediately; no done after release.
REQ-029 Macro on: LOAD 0x83 (P=3), then RUN for 12 cycles -> exactly 3 cnt_en pulses, spaced 4 cycles apart.
